// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between two producers, the arbiter and a FIFO write port.
// The master modport is the arbiter's view; slave is the producers/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    // Producer 0
    logic                  req0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  gnt0;

    // Producer 1
    logic                  req1;
    logic [DATA_WIDTH-1:0] din1;
    logic                  gnt1;

    // FIFO status and write port
    logic                  full;
    logic                  alf;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;

    // Arbiter status
    logic                  busy;

    modport master (
        input  req0,
        input  din0,
        input  req1,
        input  din1,
        input  full,
        input  alf,
        output gnt0,
        output gnt1,
        output write,
        output wdata,
        output busy
    );

    modport slave (
        output req0,
        output din0,
        output req1,
        output din1,
        output full,
        output alf,
        input  gnt0,
        input  gnt1,
        input  write,
        input  wdata,
        input  busy
    );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-producer round-robin arbiter for a single FIFO write port.
// A producer owns the port for up to BURST_LEN written beats, then the grant
// hands over directly to the other producer if it is requesting.
// Optional feature: define FIFO_ARB_ALF_THROTTLE_EN to block new grants while
// the FIFO reports almost-full (bursts already granted run to completion).
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.master bus
);

    // Encoding chosen so the grant outputs are plain register bits.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  prio_q, prio_d;

    logic                  owner_req;
    logic                  other_req;
    logic                  wr_en;
    logic                  last_beat;
    logic                  release_own;
    logic                  grant_ok;

    logic                  gnt0;
    logic                  gnt1;
    logic                  busy;
    logic [DATA_WIDTH-1:0] wdata;

`ifdef FIFO_ARB_ALF_THROTTLE_EN
    // No new ownership may start while the FIFO is almost full.
    assign grant_ok = ~bus.alf;
`else
    logic unused_alf;
    assign unused_alf = bus.alf;
    assign grant_ok   = 1'b1;
`endif

    // Requests of the current owner and of the producer waiting on it.
    always_comb begin
        owner_req = 1'b0;
        other_req = 1'b0;
        case (state_q)
            StOwn0: begin
                owner_req = bus.req0;
                other_req = bus.req1;
            end
            StOwn1: begin
                owner_req = bus.req1;
                other_req = bus.req0;
            end
            default: begin
                owner_req = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

    assign wr_en     = owner_req & ~bus.full;
    assign last_beat = (beat_cnt_q == LastBeat);

    // Full freezes everything, so a release only happens on a non-full cycle:
    // either the final beat of the burst is written or the owner has gone quiet.
    assign release_own = ~bus.full & (~owner_req | last_beat);

    // State, beat counter and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            beat_cnt_q <= 8'd0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            prio_q     <= prio_d;
        end
    end

    // Next-state: grant from idle, hand over or drop to idle on release.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    if (bus.req0 && bus.req1) begin
                        state_d = prio_q ? StOwn1 : StOwn0;
                    end else if (bus.req0) begin
                        state_d = StOwn0;
                    end else if (bus.req1) begin
                        state_d = StOwn1;
                    end
                end
            end
            StOwn0: begin
                if (release_own) begin
                    prio_d  = 1'b1;
                    state_d = (other_req && grant_ok) ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (release_own) begin
                    prio_d  = 1'b0;
                    state_d = (other_req && grant_ok) ? StOwn0 : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Beats are counted per ownership; any grant change starts afresh.
        if (state_d != state_q) begin
            beat_cnt_d = 8'd0;
        end else if (wr_en) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Outputs: grants/busy straight from state bits, write path muxed by owner.
    always_comb begin
        gnt0  = state_q[0];
        gnt1  = state_q[1];
        busy  = (state_q != StIdle);
        wdata = '0;
        case (state_q)
            StOwn0:  wdata = bus.din0;
            StOwn1:  wdata = bus.din1;
            default: wdata = '0;
        endcase
    end

    assign bus.gnt0  = gnt0;
    assign bus.gnt1  = gnt1;
    assign bus.busy  = busy;
    assign bus.write = wr_en;
    assign bus.wdata = wdata;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter with a write scoreboard.
// Each vector drives one cycle of stimulus and pushes the beat it expects to
// be written; an independent monitor pops and compares on every write strobe.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus ();
    fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .BURST_LEN (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .BURST_LEN (1)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int            tests = 0;
    int            fails = 0;
    string         scen  = "init";
    int            cyc   = 0;
    logic [7:0]    seq   = 8'd0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_exp;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s c%0d %s: got %0h, required %0h", scen, cyc, what, act, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected beat,
    // and every expected beat must appear on the cycle it was predicted for.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s c%0d unexpected write: got wdata %0h, required no write",
                             scen, cyc, bus.wdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("wdata", 32'(bus.wdata), 32'(mon_exp[DW-1:0]));
                    check("write owner gnt1", 32'(bus.gnt1), 32'(mon_exp[DW]));
                end
            end else if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s c%0d missing write: got write %0b, required 1 (data %0h)",
                         scen, cyc, bus.write, mon_exp[DW-1:0]);
            end
        end
    end

    // One cycle: drive inputs after the edge, expect gnt0/gnt1 and a write.
    task automatic step(input logic r0, input logic r1, input logic f, input logic a,
                        input logic e_g0, input logic e_g1, input logic e_wr);
        @(posedge clk);
        #1;
        seq      = seq + 8'd1;
        bus.req0 = r0;
        bus.req1 = r1;
        bus.full = f;
        bus.alf  = a;
        bus.din0 = seq;
        bus.din1 = seq ^ 8'hA5;
        if (e_wr) begin
            exp_q.push_back(e_g1 ? {1'b1, bus.din1} : {1'b0, bus.din0});
        end
        @(negedge clk);
        check("gnt0", 32'(bus.gnt0), 32'(e_g0));
        check("gnt1", 32'(bus.gnt1), 32'(e_g1));
        check("busy", 32'(bus.busy), 32'(e_g0 | e_g1));
        if (!e_g0 && !e_g1) begin
            check("idle wdata", 32'(bus.wdata), 32'd0);
        end
        cyc++;
    endtask

    // Assert reset asynchronously, check the forced outputs, then release.
    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        scen = name;
        cyc  = 0;
        check("rst gnt0", 32'(bus.gnt0), 32'd0);
        check("rst gnt1", 32'(bus.gnt1), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst write", 32'(bus.write), 32'd0);
        check("rst wdata", 32'(bus.wdata), 32'd0);
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.full  = 1'b0;
        bus.alf   = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.full  = 1'b0;
        bus.alf   = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus1.full = 1'b0;
        bus1.alf  = 1'b0;
        bus1.din0 = '0;
        bus1.din1 = '0;

        // Single requester: 4-beat burst, one idle cycle, regrant.
        do_reset("single");
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Producer 0 was released last, so contention now favours producer 1.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Both continuous: OWN0 x4, OWN1 x4, OWN0 with no idle bubble.
        do_reset("both");
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0, 1, 0, 1);
        repeat (4) step(1, 1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Full for 3 cycles after beat 2 of an OWN1 burst.
        do_reset("full");
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 1, 1);
        repeat (3) step(0, 1, 1, 0, 0, 1, 0);
        repeat (2) step(0, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Early drop by producer 0 hands straight over to producer 1.
        do_reset("handover");
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        // Producer 1 released last: producer 0 wins the next contention.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Mid-burst reset (pointer currently favours producer 1).
        scen = "midreset";
        cyc  = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #1;
        seq      = seq + 8'd1;
        bus.din0 = seq;
        check("beat3 write", 32'(bus.write), 32'd1);
        check("beat3 gnt0", 32'(bus.gnt0), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async gnt0", 32'(bus.gnt0), 32'd0);
        check("async gnt1", 32'(bus.gnt1), 32'd0);
        check("async busy", 32'(bus.busy), 32'd0);
        check("async write", 32'(bus.write), 32'd0);
        check("async wdata", 32'(bus.wdata), 32'd0);
        bus.req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        scen  = "restart";
        cyc   = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Almost-full with producer 1 requesting from idle.
        do_reset("alf");
`ifdef FIFO_ARB_ALF_THROTTLE_EN
        repeat (2) step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1);
`else
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 1);
`endif
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // BURST_LEN=1 instance: continuous requesters alternate every beat.
        do_reset("burst1");
        @(posedge clk);
        #1;
        bus1.req0 = 1'b1;
        bus1.req1 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cyc = k;
            check("bl1 gnt0", 32'(bus1.gnt0), 32'(k % 2 == 1));
            check("bl1 gnt1", 32'(bus1.gnt1), 32'(k >= 2 && k % 2 == 0));
            check("bl1 write", 32'(bus1.write), 32'(k >= 1));
        end
        @(posedge clk);
        #1;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;

        repeat (2) @(posedge clk);
        scen = "end";
        check("scoreboard left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
